psw_lock_ctrl: RTL and testbench
================================

// Module: psw_lock_ctrl
// PURPOSE
//  Parametrised successor to the switch-password lock top level. Single clock. Debounces NUM_SW switches plus a prog switch.
//  Each rising edge is taken as one digit (the switch index). Entered digits are checked against a stored code of CODE_LEN digits.
//  Adds attempt counting, lockout, entry timeout, auto-relock and run-time reprogramming of the code.
//  Drives five active-low 7-segment displays plus status flags.
// PARAMETERS
//  NUM_SW        10     switch count (2..16); digit width DW = $clog2(NUM_SW)
//  CODE_LEN      4      digits per code (1..8)
//  DEF_CODE      {4'd3,4'd1,4'd4,4'd1}   reset code, packed CODE_LEN x 4b, MS nibble = first digit
//  DEB_CYCLES    500000 stable-sample count required by the debouncer (>=2)
//  TIMEOUT_CYC   50e6*5 max idle gap between digits in ENTER before forced fail
//  OPEN_CYC      50e6*10 auto-relock delay in OPEN
//  ERR_CYC       50e6*2  ERROR display time
//  MAX_FAIL      3      consecutive failures that trigger LOCKOUT (>=1)
//  LOCK_CYC      50e6*30 LOCKOUT duration
// PORTS
//  clk       in  1        system clock
//  rst_n     in  1        synchronous, active-low reset
//  sw        in  NUM_SW   raw switches, asynchronous
//  prog      in  1        raw program-request switch, asynchronous
//  HEX4..0   out 7 each   active-low segments {g,f,e,d,c,b,a}
//  unlocked  out 1        high only in OPEN
//  alarm     out 1        high only in LOCKOUT
//  fail_cnt  out 3        consecutive failures, saturates at MAX_FAIL
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge):
//   - state=IDLE, code=DEF_CODE, fail_cnt=0, unlocked=0, alarm=0.
//   - All sync/debounce/edge regs=0; HEX shows the IDLE pattern the cycle after reset.
//   - Reset mid-entry discards partial digits and any programmed code.
//  Input path, per bit:
//   - 2-FF synchroniser, then a counter that clears whenever sync!=clean.
//   - clean<=sync when the counter hits DEB_CYCLES-1.
//   - rise = clean & ~clean_d, a 1-cycle pulse. Latency from sw change to rise = DEB_CYCLES+2 clk.
//  Digit event: exactly one sw rise bit set in a cycle. Two or more set in the same cycle = "bad" event, treated as a wrong digit.
//  FSM states (encoded in the package):
//   IDLE:    digit -> ENTER, idx=1, miss=(d!=code[0]).
//   ENTER:   digit -> idx++, miss|=(d!=code[idx]).
//            On the CODE_LEN-th digit: miss ? ERROR : OPEN. fail_cnt=0 on OPEN.
//            No digit for TIMEOUT_CYC -> ERROR.
//   ERROR:   on entry fail_cnt++ (saturating).
//            If fail_cnt reaches MAX_FAIL -> LOCKOUT next cycle; else -> IDLE after ERR_CYC.
//   LOCKOUT: all sw/prog events ignored. After LOCK_CYC: fail_cnt=0 -> IDLE.
//   OPEN:    digit -> IDLE (manual lock). prog rise -> PROG, idx=0. OPEN_CYC expiry -> IDLE.
//   PROG:    digit -> new[idx]=d, idx++. After CODE_LEN digits: code<=new -> IDLE.
//            TIMEOUT_CYC gap or bad event -> IDLE, code unchanged.
//  Rules:
//   - prog rise outside OPEN is ignored.
//   - One shared state timer, cleared on every transition and on every accepted digit.
//   - The digit compare is registered. The state change is visible 1 clk after the rise pulse.
//   - Digits >= NUM_SW are impossible; code nibbles >= NUM_SW never match.
//   - Event and timer expiry in the same cycle: the event wins.
//  Display (combinational from state/idx/fail_cnt), HEX4..HEX0:
//   - IDLE    " CodE"
//   - ENTER   "In  " + idx digit
//   - OPEN    "OPEn "
//   - ERROR   "Err  " + fail_cnt digit on HEX0
//   - LOCKOUT " LOC "
//   - PROG    "Prog" + idx digit
// STRUCTURE
//  Package psw_pkg: state encoding localparams, 7-seg glyph constants (0-9, C,o,d,E,I,n,O,P,r,g,L,blank).
//  Package psw_pkg also provides function seg7(). Debouncer/edge is one parametrised sub-module psw_debounce_edge (WIDTH, DEB_CYCLES).
//  It is instantiated once with WIDTH=NUM_SW+1. FSM, timer, code regs and display decode stay in this module.
// TESTING (NUM_SW=10, CODE_LEN=4, DEB_CYCLES=4, TIMEOUT=50, OPEN=40, ERR=10, MAX_FAIL=3, LOCK=30)
//  1 Bounce sw[3] 1-0-1 at 1-clk spacing, then hold -> exactly one rise pulse, DEB+2 clk after the last change.
//  2 Digits 3,1,4,1 -> unlocked=1 one clk after the 4th rise; HEX "OPEn"; relock to IDLE after 40 clk.
//  3 Digits 3,1,4,2 three times -> fail_cnt 1,2,3; alarm=1 for 30 clk; digits ignored; then IDLE, fail_cnt=0.
//  4 Digits 3,1 then idle 50 clk -> ERROR, fail_cnt=1; sw[3]&sw[5] same-cycle rise counts as wrong digit.
//  5 OPEN, prog rise, digits 7,7,2,0 -> IDLE; 3,1,4,1 now fails; 7,7,2,0 opens.
//  6 rst_n=0 one clk in ENTER/PROG -> IDLE, code=DEF_CODE, all outputs at reset values next clk.

Source files
------------

// File: rtl/psw_pkg.sv
// Shared types, 7-segment glyphs and the digit-to-glyph helper for the switch-password lock.
package psw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTER   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_ERROR   = 3'd3,
    ST_LOCKOUT = 3'd4,
    ST_PROG    = 3'd5
  } state_t;

  // Glyphs are active-low {g,f,e,d,c,b,a}; written as the inverse of the lit-segment pattern.
  localparam logic [6:0] SEG_0     = ~7'h3F;
  localparam logic [6:0] SEG_1     = ~7'h06;
  localparam logic [6:0] SEG_2     = ~7'h5B;
  localparam logic [6:0] SEG_3     = ~7'h4F;
  localparam logic [6:0] SEG_4     = ~7'h66;
  localparam logic [6:0] SEG_5     = ~7'h6D;
  localparam logic [6:0] SEG_6     = ~7'h7D;
  localparam logic [6:0] SEG_7     = ~7'h07;
  localparam logic [6:0] SEG_8     = ~7'h7F;
  localparam logic [6:0] SEG_9     = ~7'h6F;
  localparam logic [6:0] SEG_C     = ~7'h39;
  localparam logic [6:0] SEG_LO_O  = ~7'h5C;
  localparam logic [6:0] SEG_LO_D  = ~7'h5E;
  localparam logic [6:0] SEG_E     = ~7'h79;
  localparam logic [6:0] SEG_I     = ~7'h30;
  localparam logic [6:0] SEG_LO_N  = ~7'h54;
  localparam logic [6:0] SEG_O     = ~7'h3F;
  localparam logic [6:0] SEG_P     = ~7'h73;
  localparam logic [6:0] SEG_LO_R  = ~7'h50;
  localparam logic [6:0] SEG_LO_G  = ~7'h6F;
  localparam logic [6:0] SEG_L     = ~7'h38;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Decimal digit to glyph; anything above 9 shows blank.
  function automatic logic [6:0] seg7(input logic [3:0] val);
    case (val)
      4'd0:    seg7 = SEG_0;
      4'd1:    seg7 = SEG_1;
      4'd2:    seg7 = SEG_2;
      4'd3:    seg7 = SEG_3;
      4'd4:    seg7 = SEG_4;
      4'd5:    seg7 = SEG_5;
      4'd6:    seg7 = SEG_6;
      4'd7:    seg7 = SEG_7;
      4'd8:    seg7 = SEG_8;
      4'd9:    seg7 = SEG_9;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/psw_debounce_edge.sv
// Per-bit 2-FF synchroniser, stability debouncer and rising-edge pulse.
module psw_debounce_edge #(
  parameter int WIDTH      = 11,
  parameter int DEB_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] rise
);

  localparam int            CW       = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] sync_a;
  logic [WIDTH-1:0] sync_b;
  logic [WIDTH-1:0] clean;
  logic [WIDTH-1:0] clean_d;
  logic [CW-1:0]    cnt [WIDTH];

  // Synchronise, then accept a new level only after it differs from clean for DEB_CYCLES samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a  <= '0;
      sync_b  <= '0;
      clean   <= '0;
      clean_d <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      clean_d <= clean;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_b[i] == clean[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          clean[i] <= sync_b[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign rise = clean & ~clean_d;

endmodule

// File: rtl/psw_lock_ctrl.sv
// Switch-password lock: debounced digit entry, attempt counting, lockout, relock and reprogramming.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for the first digit, shows " CodE"
//   ENTER   | collecting digits, idx = digits taken, miss = any mismatch
//   OPEN    | code accepted, unlocked=1, relocks on digit or timer
//   ERROR   | wrong/late code, fail_cnt bumped, shown for ERR_CYC
//   LOCKOUT | too many failures, all input ignored for LOCK_CYC
//   PROG    | collecting a new code, committed only when complete
module psw_lock_ctrl
  import psw_pkg::*;
#(
  parameter int                    NUM_SW      = 10,
  parameter int                    CODE_LEN    = 4,
  parameter logic [CODE_LEN*4-1:0] DEF_CODE    = {4'd3, 4'd1, 4'd4, 4'd1},
  parameter int                    DEB_CYCLES  = 500000,
  parameter int                    TIMEOUT_CYC = 250_000_000,
  parameter int                    OPEN_CYC    = 500_000_000,
  parameter int                    ERR_CYC     = 100_000_000,
  parameter int                    MAX_FAIL    = 3,
  parameter int                    LOCK_CYC    = 1_500_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SW-1:0] sw,
  input  logic              prog,
  output logic [6:0]        HEX4,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX0,
  output logic              unlocked,
  output logic              alarm,
  output logic [2:0]        fail_cnt
);

  localparam int DW = $clog2(NUM_SW);
  localparam int CW = CODE_LEN * 4;

  logic [NUM_SW:0]   rise;
  logic [NUM_SW-1:0] rise_sw;
  logic              prog_rise;

  state_t         state, state_nx;
  logic [3:0]     idx, idx_nx;
  logic           miss, miss_nx;
  logic [2:0]     fail_nx, fail_inc;
  logic [CW-1:0]  code, code_nx;
  logic [CW-1:0]  new_code, new_nx;
  logic [31:0]    timer, timer_nx;
  logic [31:0]    limit;
  logic           any_ev, one_hot, bad, hit, last, tc, clr;
  logic [DW-1:0]  digit;
  logic [3:0]     nib;

  psw_debounce_edge #(
    .WIDTH      (NUM_SW + 1),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   ({prog, sw}),
    .rise  (rise)
  );

  assign rise_sw   = rise[NUM_SW-1:0];
  assign prog_rise = rise[NUM_SW];
  assign any_ev    = |rise_sw;
  assign one_hot   = any_ev && ((rise_sw & (rise_sw - NUM_SW'(1))) == '0);
  assign bad       = any_ev && !one_hot;

  // Digit value of the pressed switch and the stored code nibble expected at the current position.
  always_comb begin
    digit = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (rise_sw[i]) digit = DW'(i);
    end
    nib = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (idx == 4'(i)) nib = code[(CODE_LEN-1-i)*4 +: 4];
    end
  end

  // A bad event never hits, so it counts as a wrong digit wherever a digit is compared.
  assign hit      = one_hot && (nib == 4'(digit));
  assign last     = (idx == 4'(CODE_LEN - 1));
  assign fail_inc = (fail_cnt >= 3'(MAX_FAIL)) ? fail_cnt : fail_cnt + 3'd1;

  // Per-state expiry threshold for the shared timer; IDLE never expires.
  always_comb begin
    case (state)
      ST_ENTER, ST_PROG: limit = 32'(TIMEOUT_CYC);
      ST_OPEN:           limit = 32'(OPEN_CYC);
      ST_ERROR:          limit = 32'(ERR_CYC);
      ST_LOCKOUT:        limit = 32'(LOCK_CYC);
      default:           limit = '1;
    endcase
  end

  assign tc = (timer == limit - 32'd1);

  // Next-state and datapath updates; events are checked before timer expiry so they win ties.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    miss_nx  = miss;
    fail_nx  = fail_cnt;
    code_nx  = code;
    new_nx   = new_code;
    clr      = 1'b0;
    case (state)
      ST_IDLE, ST_ENTER: begin
        if (any_ev) begin
          clr = 1'b1;
          if (last) begin
            if (miss || !hit) begin
              state_nx = ST_ERROR;
              fail_nx  = fail_inc;
            end else begin
              state_nx = ST_OPEN;
              fail_nx  = '0;
            end
          end else begin
            state_nx = ST_ENTER;
            idx_nx   = idx + 4'd1;
            miss_nx  = miss || !hit;
          end
        end else if (state == ST_ENTER && tc) begin
          state_nx = ST_ERROR;
          fail_nx  = fail_inc;
        end
      end
      ST_ERROR: begin
        if (fail_cnt >= 3'(MAX_FAIL)) state_nx = ST_LOCKOUT;
        else if (tc)                  state_nx = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (tc) begin
          state_nx = ST_IDLE;
          fail_nx  = '0;
        end
      end
      ST_OPEN: begin
        if (any_ev) begin
          state_nx = ST_IDLE;
        end else if (prog_rise) begin
          state_nx = ST_PROG;
          idx_nx   = '0;
        end else if (tc) begin
          state_nx = ST_IDLE;
        end
      end
      ST_PROG: begin
        if (bad) begin
          state_nx = ST_IDLE;
        end else if (one_hot) begin
          clr = 1'b1;
          for (int i = 0; i < CODE_LEN; i++) begin
            if (idx == 4'(i)) new_nx[(CODE_LEN-1-i)*4 +: 4] = 4'(digit);
          end
          if (last) begin
            code_nx  = new_nx;
            state_nx = ST_IDLE;
          end else begin
            idx_nx = idx + 4'd1;
          end
        end else if (tc) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    if (state_nx == ST_IDLE) begin
      idx_nx  = '0;
      miss_nx = 1'b0;
    end
    timer_nx = (clr || state_nx != state) ? '0 : timer + 32'd1;
  end

  // State, entry progress, failure count, code storage and shared timer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      miss     <= 1'b0;
      fail_cnt <= '0;
      code     <= DEF_CODE;
      new_code <= '0;
      timer    <= '0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      miss     <= miss_nx;
      fail_cnt <= fail_nx;
      code     <= code_nx;
      new_code <= new_nx;
      timer    <= timer_nx;
    end
  end

  assign unlocked = (state == ST_OPEN);
  assign alarm    = (state == ST_LOCKOUT);

  // Display text per state, HEX4 is the leftmost character.
  always_comb begin
    HEX4 = SEG_BLANK;
    HEX3 = SEG_BLANK;
    HEX2 = SEG_BLANK;
    HEX1 = SEG_BLANK;
    HEX0 = SEG_BLANK;
    case (state)
      ST_IDLE: begin
        HEX3 = SEG_C;
        HEX2 = SEG_LO_O;
        HEX1 = SEG_LO_D;
        HEX0 = SEG_E;
      end
      ST_ENTER: begin
        HEX4 = SEG_I;
        HEX3 = SEG_LO_N;
        HEX0 = seg7(idx);
      end
      ST_OPEN: begin
        HEX4 = SEG_O;
        HEX3 = SEG_P;
        HEX2 = SEG_E;
        HEX1 = SEG_LO_N;
      end
      ST_ERROR: begin
        HEX4 = SEG_E;
        HEX3 = SEG_LO_R;
        HEX2 = SEG_LO_R;
        HEX0 = seg7({1'b0, fail_cnt});
      end
      ST_LOCKOUT: begin
        HEX3 = SEG_L;
        HEX2 = SEG_O;
        HEX1 = SEG_C;
      end
      ST_PROG: begin
        HEX4 = SEG_P;
        HEX3 = SEG_LO_R;
        HEX2 = SEG_LO_O;
        HEX1 = SEG_LO_G;
        HEX0 = seg7(idx);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_psw_lock_ctrl.sv
// Directed bench for psw_lock_ctrl with short timers.
module tb_psw_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] sw;
  logic       prog;
  logic [6:0] hex4, hex3, hex2, hex1, hex0;
  logic       unlocked, alarm;
  logic [2:0] fail_cnt;

  int passed = 0;
  int total  = 0;

  localparam logic [34:0] H_IDLE = {7'h7F, 7'h46, 7'h23, 7'h21, 7'h06};
  localparam logic [34:0] H_OPEN = {7'h40, 7'h0C, 7'h06, 7'h2B, 7'h7F};
  localparam logic [34:0] H_LOC  = {7'h7F, 7'h47, 7'h40, 7'h46, 7'h7F};

  psw_lock_ctrl #(
    .NUM_SW      (10),
    .CODE_LEN    (4),
    .DEF_CODE    (16'h3141),
    .DEB_CYCLES  (4),
    .TIMEOUT_CYC (50),
    .OPEN_CYC    (40),
    .ERR_CYC     (10),
    .MAX_FAIL    (3),
    .LOCK_CYC    (30)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .prog     (prog),
    .HEX4     (hex4),
    .HEX3     (hex3),
    .HEX2     (hex2),
    .HEX1     (hex1),
    .HEX0     (hex0),
    .unlocked (unlocked),
    .alarm    (alarm),
    .fail_cnt (fail_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dg(input int n);
    case (n)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [34:0] h_enter(input int n);
    return {7'h4F, 7'h2B, 7'h7F, 7'h7F, dg(n)};
  endfunction

  function automatic logic [34:0] h_err(input int n);
    return {7'h06, 7'h2F, 7'h2F, 7'h7F, dg(n)};
  endfunction

  function automatic logic [34:0] h_prog(input int n);
    return {7'h0C, 7'h2F, 7'h23, 7'h10, dg(n)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [34:0] hx, input logic u, input logic a,
                     input logic [2:0] f);
    logic [39:0] obs;
    logic [39:0] exp;
    obs = {hex4, hex3, hex2, hex1, hex0, unlocked, alarm, fail_cnt};
    exp = {hx, u, a, f};
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  // Press and release one switch; returns 8 cycles after the digit was taken.
  task automatic press(input int d);
    sw[d] = 1'b1;
    tick(7);
    sw[d] = 1'b0;
    tick(8);
  endtask

  task automatic enter4(input int a, input int b, input int c, input int d);
    press(a);
    press(b);
    press(c);
    press(d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    sw    = '0;
    prog  = 1'b0;
    tick(3);
    chk("reset", H_IDLE, 1'b0, 1'b0, 3'd0);
    rst_n = 1'b1;
    tick(2);
    chk("idle_after_reset", H_IDLE, 1'b0, 1'b0, 3'd0);

    // Bounce sw[3] 1-0-1, then hold: one digit, taken 7 clk after the last change.
    sw[3] = 1'b1; tick(1);
    sw[3] = 1'b0; tick(1);
    sw[3] = 1'b1;
    tick(6);
    chk("bounce_not_yet", H_IDLE, 1'b0, 1'b0, 3'd0);
    tick(1);
    chk("bounce_one_digit", h_enter(1), 1'b0, 1'b0, 3'd0);
    sw[3] = 1'b0;
    tick(8);
    chk("bounce_release", h_enter(1), 1'b0, 1'b0, 3'd0);

    // Complete 3,1,4,1 and watch the open window.
    press(1);
    chk("enter_idx2", h_enter(2), 1'b0, 1'b0, 3'd0);
    press(4);
    chk("enter_idx3", h_enter(3), 1'b0, 1'b0, 3'd0);
    sw[1] = 1'b1;
    tick(6);
    chk("open_not_yet", h_enter(3), 1'b0, 1'b0, 3'd0);
    tick(1);
    chk("open_now", H_OPEN, 1'b1, 1'b0, 3'd0);
    sw[1] = 1'b0;
    tick(8);
    chk("open_hold", H_OPEN, 1'b1, 1'b0, 3'd0);
    tick(31);
    chk("open_last_cycle", H_OPEN, 1'b1, 1'b0, 3'd0);
    tick(1);
    chk("auto_relock", H_IDLE, 1'b0, 1'b0, 3'd0);

    // Three wrong codes lead to lockout.
    enter4(3, 1, 4, 2);
    chk("fail1", h_err(1), 1'b0, 1'b0, 3'd1);
    tick(1);
    chk("fail1_err_last", h_err(1), 1'b0, 1'b0, 3'd1);
    tick(1);
    chk("fail1_idle", H_IDLE, 1'b0, 1'b0, 3'd1);
    enter4(3, 1, 4, 2);
    chk("fail2", h_err(2), 1'b0, 1'b0, 3'd2);
    tick(2);
    chk("fail2_idle", H_IDLE, 1'b0, 1'b0, 3'd2);
    press(3); press(1); press(4);
    sw[2] = 1'b1;
    tick(7);
    chk("fail3", h_err(3), 1'b0, 1'b0, 3'd3);
    tick(1);
    chk("lockout", H_LOC, 1'b0, 1'b1, 3'd3);
    sw[2] = 1'b0;
    tick(8);
    sw[5] = 1'b1;
    tick(7);
    chk("lockout_ignores_digit", H_LOC, 1'b0, 1'b1, 3'd3);
    sw[5] = 1'b0;
    tick(8);
    tick(6);
    chk("lockout_last_cycle", H_LOC, 1'b0, 1'b1, 3'd3);
    tick(1);
    chk("lockout_end", H_IDLE, 1'b0, 1'b0, 3'd0);

    // Entry timeout, then a two-switch event counted as a wrong digit.
    press(3); press(1);
    chk("timeout_start", h_enter(2), 1'b0, 1'b0, 3'd0);
    tick(41);
    chk("timeout_not_yet", h_enter(2), 1'b0, 1'b0, 3'd0);
    tick(1);
    chk("timeout_error", h_err(1), 1'b0, 1'b0, 3'd1);
    tick(10);
    chk("timeout_idle", H_IDLE, 1'b0, 1'b0, 3'd1);
    sw[3] = 1'b1;
    sw[5] = 1'b1;
    tick(7);
    chk("bad_event_digit", h_enter(1), 1'b0, 1'b0, 3'd1);
    sw[3] = 1'b0;
    sw[5] = 1'b0;
    tick(8);
    press(1); press(4); press(1);
    chk("bad_event_fails", h_err(2), 1'b0, 1'b0, 3'd2);
    tick(2);

    // Reprogram to 7,7,2,0.
    enter4(3, 1, 4, 1);
    chk("open_clears_fail", H_OPEN, 1'b1, 1'b0, 3'd0);
    prog = 1'b1;
    tick(7);
    chk("prog_enter", h_prog(0), 1'b0, 1'b0, 3'd0);
    prog = 1'b0;
    tick(8);
    press(7);
    chk("prog_idx1", h_prog(1), 1'b0, 1'b0, 3'd0);
    press(7); press(2);
    chk("prog_idx3", h_prog(3), 1'b0, 1'b0, 3'd0);
    press(0);
    chk("prog_done", H_IDLE, 1'b0, 1'b0, 3'd0);
    enter4(3, 1, 4, 1);
    chk("old_code_fails", h_err(1), 1'b0, 1'b0, 3'd1);
    tick(2);
    enter4(7, 7, 2, 0);
    chk("new_code_opens", H_OPEN, 1'b1, 1'b0, 3'd0);

    // Manual lock, then reset in the middle of ENTER and of PROG.
    press(5);
    chk("manual_lock", H_IDLE, 1'b0, 1'b0, 3'd0);
    enter4(3, 1, 4, 1);
    chk("before_reset_fail", h_err(1), 1'b0, 1'b0, 3'd1);
    tick(2);
    press(7);
    chk("before_reset_enter", h_enter(1), 1'b0, 1'b0, 3'd1);
    rst_n = 1'b0;
    tick(1);
    chk("reset_in_enter", H_IDLE, 1'b0, 1'b0, 3'd0);
    rst_n = 1'b1;
    tick(1);
    enter4(7, 7, 2, 0);
    chk("reset_restores_code", h_err(1), 1'b0, 1'b0, 3'd1);
    tick(2);
    enter4(3, 1, 4, 1);
    chk("default_code_opens", H_OPEN, 1'b1, 1'b0, 3'd0);
    prog = 1'b1;
    tick(7);
    prog = 1'b0;
    tick(8);
    press(9);
    chk("prog_before_reset", h_prog(1), 1'b0, 1'b0, 3'd0);
    rst_n = 1'b0;
    tick(1);
    chk("reset_in_prog", H_IDLE, 1'b0, 1'b0, 3'd0);
    rst_n = 1'b1;
    tick(1);
    enter4(3, 1, 4, 1);
    chk("code_kept_after_prog_reset", H_OPEN, 1'b1, 1'b0, 3'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
